// File: rtl/pixel_stream_buffer.sv
// Raster pixel request sequencer feeding a first-word fall-through FIFO toward the projective transform.
// Define PSB_COORD_CHECK_EN to add the sticky coord_error output for out-of-raster-order coordinates.
`ifndef IMAGE_WIDTH
`define IMAGE_WIDTH 640
`endif
`ifndef IMAGE_HEIGHT
`define IMAGE_HEIGHT 480
`endif
`ifndef LOG_TRUNC
`define LOG_TRUNC 8
`endif

module pixel_stream_buffer #(
    parameter int unsigned LOG_DEPTH = 3,
    parameter int unsigned LAST_X    = `IMAGE_WIDTH - 1,
    parameter int unsigned LAST_Y    = `IMAGE_HEIGHT - 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_flag,
    output logic                  request,
    input  logic [`LOG_TRUNC-1:0] pixel,
    input  logic [9:0]            x_in,
    input  logic [8:0]            y_in,
    input  logic                  pixel_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [`LOG_TRUNC-1:0] out_pixel,
    output logic [9:0]            out_x,
    output logic [8:0]            out_y,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  spurious
`ifdef PSB_COORD_CHECK_EN
    ,
    output logic                  coord_error
`endif
);

    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam int unsigned EW    = `LOG_TRUNC + 19;
    localparam logic [LOG_DEPTH:0] DEPTH_CNT = {1'b1, {LOG_DEPTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

    state_t               state, state_next;
    logic                 push, pop, flush, stray, last_in;
    logic [EW-1:0]        mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [LOG_DEPTH:0]   count;

    assign last_in = (x_in == 10'(LAST_X)) && (y_in == 9'(LAST_Y));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        request    = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        stray      = 1'b0;
        case (state)
            IDLE: begin
                stray = pixel_flag;
                if (frame_flag) state_next = REQ;
            end
            REQ: begin
                stray = pixel_flag;
                if (frame_flag) begin
                    flush = 1'b1;
                end else if (count < DEPTH_CNT) begin
                    request    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (frame_flag) begin
                    flush      = 1'b1;
                    state_next = pixel_flag ? REQ : DRAIN;
                end else if (pixel_flag) begin
                    push       = 1'b1;
                    state_next = last_in ? DONE : REQ;
                end
            end
            DRAIN: begin
                // A returning pixel ends the drain even if a new frame_flag flushes in the same cycle.
                flush = frame_flag;
                if (pixel_flag) state_next = REQ;
            end
            DONE: begin
                stray = pixel_flag;
                if (frame_flag) begin
                    flush      = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid = (count != '0);
    assign {out_pixel, out_x, out_y} = mem[rd_ptr];
    assign out_last  = out_valid && (out_x == 10'(LAST_X)) && (out_y == 9'(LAST_Y));
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {pixel, x_in, y_in};
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_done <= 1'b0;
            spurious   <= 1'b0;
        end else begin
            frame_done <= pop && out_last;
            spurious   <= spurious || stray;
        end
    end

`ifdef PSB_COORD_CHECK_EN
    logic [9:0] exp_x;
    logic [8:0] exp_y;

    always_ff @(posedge clock) begin
        if (reset) begin
            exp_x       <= '0;
            exp_y       <= '0;
            coord_error <= 1'b0;
        end else begin
            if (frame_flag) begin
                exp_x <= '0;
                exp_y <= '0;
            end else if (push) begin
                if (exp_x == 10'(LAST_X)) begin
                    exp_x <= '0;
                    exp_y <= exp_y + 1'b1;
                end else begin
                    exp_x <= exp_x + 1'b1;
                end
            end
            if (push && ((x_in != exp_x) || (y_in != exp_y))) coord_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Scoreboard bench for pixel_stream_buffer: LPF responder model with random latency and a queue of expected FIFO contents.
// A small frame (8x4) keeps full-frame runs short; PSB_COORD_CHECK_EN enables the coordinate-error test.
`ifndef LOG_TRUNC
`define LOG_TRUNC 8
`endif

module tb_pixel_stream_buffer;

    localparam int LX = 7;
    localparam int LY = 3;
    localparam int PW = `LOG_TRUNC;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [9:0]    x;
        logic [8:0]    y;
    } ent_t;

    logic          clock, reset, frame_flag, request, pixel_flag;
    logic [PW-1:0] pixel, out_pixel;
    logic [9:0]    x_in, out_x;
    logic [8:0]    y_in, out_y;
    logic          out_valid, out_ready, out_last, frame_done, spurious;
`ifdef PSB_COORD_CHECK_EN
    logic          coord_error;
`endif

    pixel_stream_buffer #(.LOG_DEPTH(3), .LAST_X(LX), .LAST_Y(LY)) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_flag (frame_flag),
        .request    (request),
        .pixel      (pixel),
        .x_in       (x_in),
        .y_in       (y_in),
        .pixel_flag (pixel_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .frame_done (frame_done),
        .spurious   (spurious)
`ifdef PSB_COORD_CHECK_EN
        ,
        .coord_error(coord_error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t exp_q[$];
    bit   mon_en    = 0;
    bit   pend_done = 0;
    int   n_done    = 0;

    // LPF model state: one outstanding request, countdown to its response, and the raster position it will return.
    bit pend = 0, discard = 0;
    int cnt = 0, ex = 0, ey = 0, resp_idx = 0, corrupt_idx = -1;
    int lat_lo = 1, lat_hi = 4, ready_mode = 0, n_req = 0, snap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit ff = 1'b0, input bit inj = 1'b0, input bit rst = 1'b0);
        ent_t e;
        @(posedge clock);
        #1;
        reset      = rst;
        frame_flag = ff;
        pixel_flag = 1'b0;
        if (ready_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
        else                 out_ready = (ready_mode == 1);
        if (ff || rst) begin
            if (pend) discard = 1;
            exp_q.delete();
            ex = 0; ey = 0; resp_idx = 0;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend       = 0;
                pixel_flag = 1'b1;
                pixel      = PW'($urandom);
                x_in       = 10'((resp_idx == corrupt_idx && !discard) ? ex + 1 : ex);
                y_in       = 9'(ey);
                if (!discard) begin
                    e.p = pixel; e.x = x_in; e.y = y_in;
                    exp_q.push_back(e);
                    resp_idx++;
                    ex = int'(x_in);
                    if (ex >= LX) begin ex = 0; ey++; end
                    else ex++;
                end
            end
        end
        if (inj) begin
            pixel_flag = 1'b1;
            pixel      = PW'($urandom);
            x_in       = 10'($urandom_range(0, LX));
            y_in       = 9'($urandom_range(0, LY));
        end
        #3;
        if (request) begin
            n_req++;
            check("one_outstanding", 32'(pend), 0);
            pend    = 1;
            discard = 0;
            cnt     = int'($urandom_range(lat_lo, lat_hi));
        end
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 3000 && n_done < target; i++) cyc();
        check(name, n_done, target);
    endtask

    // Monitor: pops the expected queue whenever the DUT will accept a pop at the coming edge.
    always @(negedge clock) begin
        if (mon_en) begin
            ent_t e;
            bit   popping;
            check("frame_done", 32'(frame_done), 32'(pend_done));
            if (frame_done) n_done++;
            popping   = out_valid && out_ready && !frame_flag && !reset;
            pend_done = 0;
            if (popping) begin
                if (exp_q.size() == 0) begin
                    check("pop_without_expected_entry", 32'(out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", 32'(out_pixel), 32'(e.p));
                    check("out_x", 32'(out_x), 32'(e.x));
                    check("out_y", 32'(out_y), 32'(e.y));
                    check("out_last", 32'(out_last), 32'(e.x == LX && e.y == LY));
                    pend_done = (e.x == LX && e.y == LY);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; frame_flag = 1'b0; pixel_flag = 1'b0;
        pixel = '0; x_in = '0; y_in = '0; out_ready = 1'b0;
        repeat (2) cyc(0, 0, 1);
        cyc();
        mon_en = 1;
        check("reset_request", 32'(request), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_spurious", 32'(spurious), 0);

        // Consumer stalled: exactly DEPTH requests, then one pop frees one slot.
        lat_lo = 3; lat_hi = 3; ready_mode = 0; n_req = 0;
        cyc(1);
        repeat (80) cyc();
        check("requests_until_full", n_req, 8);
        check("request_low_when_full", 32'(request), 0);
        check("out_valid_when_full", 32'(out_valid), 1);
        ready_mode = 1;
        cyc();
        ready_mode = 0;
        repeat (20) cyc();
        check("one_request_after_pop", n_req, 9);

        // Finish the frame with random backpressure and latency.
        ready_mode = 2; lat_lo = 1; lat_hi = 4;
        wait_done(1, "frame1_done_count");
        snap = n_req;
        repeat (20) cyc();
        check("frame1_requests", n_req, (LX + 1) * (LY + 1));
        check("no_request_after_done", n_req, snap);
        check("frame1_drained", exp_q.size(), 0);
        check("frame1_out_valid_low", 32'(out_valid), 0);

        // frame_flag one cycle after a request: the returning pixel is dropped and the frame restarts at (0,0).
        lat_lo = 3; lat_hi = 3; ready_mode = 1; n_req = 0;
        cyc(1);
        for (int i = 0; i < 50 && n_req == 0; i++) cyc();
        check("frame2_first_request", n_req, 1);
        cyc(1);
        repeat (2) cyc();
        check("drain_empty", 32'(out_valid), 0);
        for (int i = 0; i < 50 && n_req < 2; i++) cyc();
        check("request_after_drain", n_req, 2);
        ready_mode = 2; lat_lo = 1; lat_hi = 4;
        wait_done(2, "frame2_done_count");
        repeat (10) cyc();
        check("frame2_requests", n_req, (LX + 1) * (LY + 1) + 1);
        check("frame2_no_spurious", 32'(spurious), 0);

        // Stray pixel_flag in IDLE.
        cyc(0, 0, 1);
        cyc();
        cyc(0, 1);
        cyc();
        check("spurious_set", 32'(spurious), 1);
        check("spurious_no_push", 32'(out_valid), 0);
        repeat (5) cyc();
        check("spurious_sticky", 32'(spurious), 1);
        cyc(0, 0, 1);
        cyc();
        check("spurious_cleared_by_reset", 32'(spurious), 0);

        // Reset while a request is outstanding: the late pixel lands in IDLE.
        lat_lo = 3; lat_hi = 3; ready_mode = 1; n_req = 0;
        cyc(1);
        for (int i = 0; i < 50 && n_req == 0; i++) cyc();
        cyc(0, 0, 1);
        repeat (4) cyc();
        check("spurious_after_reset_in_wait", 32'(spurious), 1);
        check("no_request_after_reset", n_req, 1);
        check("empty_after_reset_in_wait", 32'(out_valid), 0);

`ifdef PSB_COORD_CHECK_EN
        cyc(0, 0, 1);
        cyc();
        check("coord_error_reset", 32'(coord_error), 0);
        corrupt_idx = 4; lat_lo = 1; lat_hi = 4; ready_mode = 1;
        snap = n_done;
        cyc(1);
        for (int i = 0; i < 200 && resp_idx < 4; i++) cyc();
        check("coord_error_before_bad", 32'(coord_error), 0);
        for (int i = 0; i < 200 && resp_idx < 5; i++) cyc();
        repeat (2) cyc();
        check("coord_error_set", 32'(coord_error), 1);
        wait_done(snap + 1, "coord_frame_done");
        corrupt_idx = -1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
